// File: rtl/timer_periph.sv
// rtl/timer_periph.sv - APB timer with prescaler, auto-reload and update flag; IE/irq built only with TIMER_PERIPH_IRQ_EN
module timer_periph #(
  parameter int CNT_WIDTH = 32
) (
  input  logic        PCLK,
  input  logic        PRESET,
  input  logic [31:0] PADDR,
  input  logic [31:0] PWDATA,
  input  logic        PWRITE,
  input  logic        PENABLE,
  input  logic        PSEL,
  output logic [31:0] PRDATA,
  output logic        PREADY,
  output logic        irq
);

  typedef enum logic [1:0] {ST_IDLE, ST_READY, ST_DONE} apb_state_t;

  localparam logic [CNT_WIDTH-1:0] ONE = CNT_WIDTH'(1);

  apb_state_t           state, state_nxt;
  logic                 start;
  logic [2:0]           reg_sel;
  logic                 wr_q;
  logic [31:0]          wdata_q;
  logic                 en, ie, uf;
  logic [CNT_WIDTH-1:0] pcnt, tcnt, psc, arr;
  logic [31:0]          rd_mux;
  logic                 wr_commit, tcr_wr, psc_wr, arr_wr, tsr_wr;
  logic                 clr_pulse, tick, wrap;
  logic                 unused_addr;

  assign unused_addr = ^{PADDR[31:5], PADDR[1:0]};

  // APB handshake state register
  always_ff @(posedge PCLK or negedge PRESET) begin
    if (!PRESET) state <= ST_IDLE;
    else         state <= state_nxt;
  end

  // READY lasts one cycle; DONE waits for the master to leave the access phase
  always_comb begin
    state_nxt = state;
    start     = 1'b0;
    case (state)
      ST_IDLE: begin
        if (PSEL && PENABLE) begin
          state_nxt = ST_READY;
          start     = 1'b1;
        end
      end
      ST_READY: state_nxt = ST_DONE;
      ST_DONE:  if (!(PSEL && PENABLE)) state_nxt = ST_IDLE;
      default:  state_nxt = ST_IDLE;
    endcase
  end

  assign PREADY = (state == ST_READY);

  // Latch the request on the first access edge so the commit uses stable values
  always_ff @(posedge PCLK or negedge PRESET) begin
    if (!PRESET) begin
      reg_sel <= 3'd0;
      wr_q    <= 1'b0;
      wdata_q <= 32'd0;
    end else if (start) begin
      reg_sel <= PADDR[4:2];
      wr_q    <= PWRITE;
      wdata_q <= PWDATA;
    end
  end

  // Read mux, zero-extended to the bus width
  always_comb begin
    rd_mux = 32'd0;
    case (PADDR[4:2])
      3'd0:    rd_mux = {29'd0, ie, 1'b0, en};
      3'd1:    rd_mux = 32'(tcnt);
      3'd2:    rd_mux = 32'(psc);
      3'd3:    rd_mux = 32'(arr);
      3'd4:    rd_mux = {31'd0, uf};
      default: rd_mux = 32'd0;
    endcase
  end

  // PRDATA is non-zero only during the PREADY cycle of a read
  always_ff @(posedge PCLK or negedge PRESET) begin
    if (!PRESET)                PRDATA <= 32'd0;
    else if (start && !PWRITE)  PRDATA <= rd_mux;
    else                        PRDATA <= 32'd0;
  end

  // A write commits on the edge ending PREADY, only if the master still holds the access
  assign wr_commit = (state == ST_READY) && PSEL && PENABLE && wr_q;
  assign tcr_wr    = wr_commit && (reg_sel == 3'd0);
  assign psc_wr    = wr_commit && (reg_sel == 3'd2);
  assign arr_wr    = wr_commit && (reg_sel == 3'd3);
  assign tsr_wr    = wr_commit && (reg_sel == 3'd4);
  assign clr_pulse = tcr_wr && wdata_q[1];
  assign tick      = en && (pcnt == psc);
  assign wrap      = tick && (tcnt >= arr) && !clr_pulse;

  // Configuration registers
  always_ff @(posedge PCLK or negedge PRESET) begin
    if (!PRESET) begin
      en  <= 1'b0;
      psc <= '0;
      arr <= '1;
    end else begin
      if (tcr_wr) en  <= wdata_q[0];
      if (psc_wr) psc <= wdata_q[CNT_WIDTH-1:0];
      if (arr_wr) arr <= wdata_q[CNT_WIDTH-1:0];
    end
  end

  // Prescaler and main counter; CLR beats a same-cycle tick
  always_ff @(posedge PCLK or negedge PRESET) begin
    if (!PRESET) begin
      pcnt <= '0;
      tcnt <= '0;
    end else if (clr_pulse) begin
      pcnt <= '0;
      tcnt <= '0;
    end else if (en) begin
      pcnt <= tick ? '0 : pcnt + ONE;
      if (tick) tcnt <= (tcnt >= arr) ? '0 : tcnt + ONE;
    end
  end

  // Update flag: hardware set wins over a same-edge software clear
  always_ff @(posedge PCLK or negedge PRESET) begin
    if (!PRESET)                    uf <= 1'b0;
    else if (wrap)                  uf <= 1'b1;
    else if (tsr_wr && wdata_q[0])  uf <= 1'b0;
  end

`ifdef TIMER_PERIPH_IRQ_EN
  logic irq_q;

  // Interrupt enable and registered interrupt level
  always_ff @(posedge PCLK or negedge PRESET) begin
    if (!PRESET) begin
      ie    <= 1'b0;
      irq_q <= 1'b0;
    end else begin
      if (tcr_wr) ie <= wdata_q[2];
      irq_q <= uf & ie;
    end
  end

  assign irq = irq_q;
`else
  assign ie  = 1'b0;
  assign irq = 1'b0;
`endif

endmodule
